// File: rtl/dpram_fifo_ctrl.sv
// rtl/dpram_fifo_ctrl.sv - FIFO controller for a 64x8 dual-port RAM
// Port A pushes, port B prefetches the head word into an output register.
module dpram_fifo_ctrl #(
   parameter int DW = 8,
   parameter int AW = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW:0]   count,
   output logic [AW-1:0] ad_a,
   output logic [DW-1:0] data_a,
   output logic          wre_a,
   output logic [AW-1:0] ad_b,
   output logic [DW-1:0] data_b,
   output logic          wre_b,
   input  logic [DW-1:0] q_b
);

   localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

   typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

   state_t        state_q, state_d;
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic [DW-1:0] out_data_q, out_data_d;
   logic [AW:0]   mem_cnt;
   logic          push;
   logic          issue;

   assign mem_cnt  = wr_ptr_q - rd_ptr_q;
   assign in_ready = !rst && (mem_cnt != FULL_CNT);
   assign push     = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         out_data_q <= out_data_d;
      end
   end

   // An issue presents rd_ptr to port B this edge; the word lands in out_data one edge later.
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      out_data_d = out_data_q;
      issue      = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_cnt != '0) begin
               issue   = 1'b1;
               state_d = FETCH;
            end
         end
         FETCH: begin
            out_data_d = q_b;
            state_d    = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               if (mem_cnt != '0) begin
                  issue   = 1'b1;
                  state_d = FETCH;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (issue) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push)  wr_ptr_d = wr_ptr_q + 1'b1;
      if (clr) begin
         state_d    = IDLE;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         out_data_d = '0;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = (state_q == HOLD);
   assign count     = mem_cnt + {{AW{1'b0}}, (state_q != IDLE)};

   assign ad_a   = wr_ptr_q[AW-1:0];
   assign data_a = in_data;
   assign wre_a  = push && !clr;
   assign ad_b   = rd_ptr_q[AW-1:0];
   assign data_b = '0;
   assign wre_b  = 1'b0;

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// tb/tb_dpram_fifo_ctrl.sv - directed self-checking bench for dpram_fifo_ctrl
// Includes a behavioural 64x8 RAM and a queue model of the FIFO contents.
module tb_dpram_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst, clr;
   logic [7:0] in_data;
   logic       in_valid, in_ready;
   logic [7:0] out_data;
   logic       out_valid, out_ready;
   logic [6:0] count;
   logic [5:0] ad_a, ad_b;
   logic [7:0] data_a, data_b, q_b;
   logic       wre_a, wre_b;

   logic [7:0] mem [64];
   logic [7:0] model [$];
   int         pop_cyc [$];
   int         n_checks = 0;
   int         n_errors = 0;
   int         cyc = 0;
   int         pops = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (wre_a) mem[ad_a] <= data_a;
      q_b <= mem[ad_b];
   end

   dpram_fifo_ctrl dut (
      .clk(clk), .rst(rst), .clr(clr),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .count(count),
      .ad_a(ad_a), .data_a(data_a), .wre_a(wre_a),
      .ad_b(ad_b), .data_b(data_b), .wre_b(wre_b),
      .q_b(q_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: capture handshakes before the edge, update the model after it.
   task automatic cycle();
      logic       do_push, do_pop, do_clr;
      logic [7:0] push_d, pop_d;
      do_clr  = clr;
      do_push = in_valid && in_ready;
      push_d  = in_data;
      do_pop  = out_valid && out_ready;
      pop_d   = out_data;
      @(posedge clk);
      #1;
      cyc++;
      if (do_clr) begin
         model.delete();
      end else begin
         if (do_pop) begin
            if (model.size() == 0) check("pop_underflow", 1, 0);
            else check("pop_data", {24'd0, pop_d}, {24'd0, model.pop_front()});
            pops++;
            pop_cyc.push_back(cyc);
         end
         if (do_push) model.push_back(push_d);
      end
   endtask

   initial begin
      int n_acc;
      int sent;
      int bound;
      logic acc;
      rst = 1'b1; clr = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_count", count, 0);
      check("rst_out_valid", out_valid, 0);
      check("wre_b_tied", wre_b, 0);
      check("data_b_tied", data_b, 0);
      rst = 1'b0;
      #1;
      check("rel_in_ready", in_ready, 1);

      // reset mid-FETCH
      in_data = 8'h99; in_valid = 1'b1; cycle(); in_valid = 1'b0;
      cycle();
      check("fetch_out_valid", out_valid, 0);
      check("fetch_count", count, 1);
      in_valid = 1'b1;
      #1 rst = 1'b1;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_count", count, 0);
      check("midrst_in_ready", in_ready, 0);
      check("midrst_wre_a", wre_a, 0);
      model.delete();
      @(posedge clk);
      #1 rst = 1'b0; in_valid = 1'b0;
      #1;
      check("midrst_rel_in_ready", in_ready, 1);
      check("midrst_rel_count", count, 0);

      // single word, latency
      in_data = 8'h22; in_valid = 1'b1; cycle(); in_valid = 1'b0;
      check("single_ad_a", ad_a, 1);
      check("single_n1_valid", out_valid, 0);
      cycle();
      check("single_n2_prev_valid", out_valid, 0);
      cycle();
      check("single_valid", out_valid, 1);
      check("single_data", out_data, 8'h22);
      check("single_count", count, 1);
      cycle();
      check("single_stable", out_data, 8'h22);
      out_ready = 1'b1; cycle(); out_ready = 1'b0;
      check("single_empty_count", count, 0);

      // order and throughput
      pop_cyc.delete();
      out_ready = 1'b1;
      foreach (model[i]) check("model_empty", 1, 0);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data = (i == 0) ? 8'h22 : (i == 1) ? 8'h34 : (i == 2) ? 8'h45 : 8'h77;
         cycle();
      end
      in_valid = 1'b0;
      repeat (8) cycle();
      out_ready = 1'b0;
      check("order_pops", pop_cyc.size(), 4);
      for (int i = 1; i < pop_cyc.size(); i++)
         check("order_interval", pop_cyc[i] - pop_cyc[i-1], 2);
      check("order_count", count, 0);

      // full
      n_acc = 0;
      for (int i = 0; i < 70; i++) begin
         in_valid = 1'b1; in_data = n_acc[7:0];
         acc = in_ready;
         cycle();
         if (acc) n_acc++;
      end
      in_valid = 1'b0;
      check("full_accepted", n_acc, 65);
      check("full_count", count, 65);
      check("full_in_ready", in_ready, 0);
      out_ready = 1'b1; cycle(); out_ready = 1'b0;
      check("full_pop_in_ready", in_ready, 1);
      check("full_pop_count", count, 64);
      out_ready = 1'b1;
      bound = 0;
      while (count != 0 && bound < 400) begin cycle(); bound++; end
      out_ready = 1'b0;
      check("full_drain_count", count, 0);
      check("full_drain_model", model.size(), 0);

      // wrap stream with random back-pressure
      sent = 0; pops = 0; bound = 0;
      while ((sent < 200 || count != 0) && bound < 3000) begin
         in_valid = (sent < 200);
         in_data = sent[7:0];
         out_ready = 1'($urandom_range(0, 1));
         acc = in_valid && in_ready;
         cycle();
         if (acc) sent++;
         bound++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      check("wrap_sent", sent, 200);
      check("wrap_pops", pops, 200);
      check("wrap_model", model.size(), 0);

      // clr
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = 8'h50 + 8'(i); cycle();
      end
      in_valid = 1'b0;
      repeat (2) cycle();
      check("clr_pre_count", count, 5);
      check("clr_pre_valid", out_valid, 1);
      in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1; clr = 1'b1;
      #1;
      check("clr_in_ready", in_ready, 1);
      check("clr_wre_a", wre_a, 0);
      cycle();
      clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      check("clr_count", count, 0);
      check("clr_out_valid", out_valid, 0);
      check("clr_out_data", out_data, 0);
      in_data = 8'h5C; in_valid = 1'b1; cycle(); in_valid = 1'b0;
      repeat (2) cycle();
      check("post_clr_data", out_data, 8'h5C);
      check("post_clr_count", count, 1);
      out_ready = 1'b1; cycle(); out_ready = 1'b0;
      check("post_clr_empty", count, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
